// File: rtl/prio_mixer_ram.sv
// rtl/prio_mixer_ram.sv - RAM-based sprite/layer priority mixer with CPU-writable, self-initialising table
module prio_mixer_ram #(
  parameter int NUM_LAYERS = 4,
  parameter int PRI_BITS   = 3,
  parameter int OUT_W      = 4,
  localparam int ADDR_W    = 1 + NUM_LAYERS + PRI_BITS
) (
  input  logic                  CLK,
  input  logic                  RSTn,
  input  logic                  PIX_CE,
  input  logic                  PIX_VLD,
  input  logic                  BANK,
  input  logic [PRI_BITS-1:0]   OBP,
  input  logic [NUM_LAYERS-1:0] OPQ,
  input  logic                  EN1n,
  input  logic                  EN2n,
  output logic [OUT_W-1:0]      Q,
  output logic                  Q_VLD,
  input  logic                  CPU_WE,
  input  logic                  CPU_RE,
  input  logic [ADDR_W-1:0]     CPU_ADDR,
  input  logic [OUT_W-1:0]      CPU_DIN,
  output logic [OUT_W-1:0]      CPU_DOUT,
  output logic                  CPU_RDY,
  input  logic                  INIT_REQ,
  output logic                  BUSY
);

  typedef enum logic {ST_INIT, ST_IDLE} state_t;

  logic [OUT_W-1:0] mem [2**ADDR_W];

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                busy_q, busy_d;
  logic [OUT_W-1:0]    cpu_dout_q, cpu_dout_d;
  logic                cpu_rdy_q, cpu_rdy_d;
  logic [ADDR_W-1:0]   s1_addr_q, s1_addr_d;
  logic                s1_vld_q, s1_vld_d;
  logic                s1_en_q, s1_en_d;
  logic                s2_sel_q, s2_sel_d;
  logic                s2_vld_q, s2_vld_d;
  logic [OUT_W-1:0]    rd_a_q;

  logic                we_b;
  logic [ADDR_W-1:0]   addr_b;
  logic [OUT_W-1:0]    wdata_b;

  // Default order: lowest set opacity bit wins; no opaque layer selects the backdrop.
  function automatic logic [OUT_W-1:0] def_entry(input logic [ADDR_W-1:0] addr);
    logic [OUT_W-1:0] r;
    r = '1;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (addr[i]) r = OUT_W'(i);
    end
    return r;
  endfunction

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    cpu_dout_d = cpu_dout_q;
    cpu_rdy_d  = 1'b0;
    we_b       = 1'b0;
    addr_b     = CPU_ADDR;
    wdata_b    = CPU_DIN;
    case (state_q)
      ST_INIT: begin
        we_b    = 1'b1;
        addr_b  = cnt_q;
        wdata_b = def_entry(cnt_q);
        cnt_d   = cnt_q + ADDR_W'(1);
        if (cnt_q == '1) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      end
      ST_IDLE: begin
        we_b = CPU_WE;
        if (CPU_RE) begin
          cpu_dout_d = mem[CPU_ADDR];
          cpu_rdy_d  = 1'b1;
        end
        if (INIT_REQ) begin
          state_d = ST_INIT;
          busy_d  = 1'b1;
          cnt_d   = '0;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_comb begin
    s1_addr_d = s1_addr_q;
    s1_vld_d  = s1_vld_q;
    s1_en_d   = s1_en_q;
    s2_sel_d  = s2_sel_q;
    s2_vld_d  = s2_vld_q;
    if (PIX_CE) begin
      s1_addr_d = {BANK, OBP, OPQ};
      s1_vld_d  = PIX_VLD;
      s1_en_d   = ~EN1n & ~EN2n;
      s2_sel_d  = s1_en_q & ~busy_q;
      s2_vld_d  = s1_vld_q;
    end
  end

  // Both ports read with non-blocking semantics, so a same-edge write is seen as old data.
  always_ff @(posedge CLK) begin
    if (we_b) mem[addr_b] <= wdata_b;
    if (PIX_CE) rd_a_q <= mem[s1_addr_q];
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q    <= ST_INIT;
      cnt_q      <= '0;
      busy_q     <= 1'b1;
      cpu_dout_q <= '0;
      cpu_rdy_q  <= 1'b0;
      s1_addr_q  <= '0;
      s1_vld_q   <= 1'b0;
      s1_en_q    <= 1'b0;
      s2_sel_q   <= 1'b0;
      s2_vld_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      cpu_dout_q <= cpu_dout_d;
      cpu_rdy_q  <= cpu_rdy_d;
      s1_addr_q  <= s1_addr_d;
      s1_vld_q   <= s1_vld_d;
      s1_en_q    <= s1_en_d;
      s2_sel_q   <= s2_sel_d;
      s2_vld_q   <= s2_vld_d;
    end
  end

  assign Q        = s2_sel_q ? rd_a_q : '1;
  assign Q_VLD    = s2_vld_q;
  assign CPU_DOUT = cpu_dout_q;
  assign CPU_RDY  = cpu_rdy_q;
  assign BUSY     = busy_q;

endmodule

// File: tb/tb_prio_mixer_ram.sv
// tb/tb_prio_mixer_ram.sv - directed bench for prio_mixer_ram with a lookup scoreboard
module tb_prio_mixer_ram;
  localparam int NL = 4;
  localparam int PB = 3;
  localparam int OW = 4;
  localparam int AW = 8;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic          RSTn, PIX_CE, PIX_VLD, BANK, EN1n, EN2n;
  logic [PB-1:0] OBP;
  logic [NL-1:0] OPQ;
  logic [OW-1:0] Q, CPU_DIN, CPU_DOUT;
  logic          Q_VLD, CPU_WE, CPU_RE, CPU_RDY, INIT_REQ, BUSY;
  logic [AW-1:0] CPU_ADDR;

  prio_mixer_ram #(.NUM_LAYERS(NL), .PRI_BITS(PB), .OUT_W(OW)) dut (
    .CLK(CLK), .RSTn(RSTn), .PIX_CE(PIX_CE), .PIX_VLD(PIX_VLD), .BANK(BANK),
    .OBP(OBP), .OPQ(OPQ), .EN1n(EN1n), .EN2n(EN2n), .Q(Q), .Q_VLD(Q_VLD),
    .CPU_WE(CPU_WE), .CPU_RE(CPU_RE), .CPU_ADDR(CPU_ADDR), .CPU_DIN(CPU_DIN),
    .CPU_DOUT(CPU_DOUT), .CPU_RDY(CPU_RDY), .INIT_REQ(INIT_REQ), .BUSY(BUSY)
  );

  typedef struct packed {
    logic          vld;
    logic [OW-1:0] q;
  } exp_t;

  int            total = 0;
  int            bad = 0;
  logic [OW-1:0] exp_mem [256];
  exp_t          sb[$];
  exp_t          last;
  logic          have_last;
  logic          tb_busy;

  function automatic logic [OW-1:0] ref_def(input logic [AW-1:0] a);
    for (int i = 0; i < NL; i++) if (a[i]) return OW'(i);
    return 4'hF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pix(input logic ce, input logic vld, input logic bank, input logic [PB-1:0] obp,
                     input logic [NL-1:0] opq, input logic e1, input logic e2);
    exp_t e;
    logic popped;
    PIX_CE = ce; PIX_VLD = vld; BANK = bank; OBP = obp; OPQ = opq; EN1n = e1; EN2n = e2;
    if (ce) begin
      e.vld = vld;
      e.q   = (!e1 && !e2 && !tb_busy) ? exp_mem[{bank, obp, opq}] : 4'hF;
      sb.push_back(e);
    end
    @(posedge CLK); #1;
    popped = 1'b0;
    if (ce && sb.size() > 1) begin
      last = sb.pop_front();
      have_last = 1'b1;
      popped = 1'b1;
    end
    if (popped) begin
      chk("pix_q", 32'(Q), 32'(last.q));
      chk("pix_vld", 32'(Q_VLD), 32'(last.vld));
    end else if (!ce && have_last) begin
      chk("hold_q", 32'(Q), 32'(last.q));
      chk("hold_vld", 32'(Q_VLD), 32'(last.vld));
    end
  endtask

  task automatic drain();
    pix(1'b1, 1'b0, 1'b0, '0, '0, 1'b1, 1'b1);
  endtask

  task automatic cpu_wr(input logic [AW-1:0] a, input logic [OW-1:0] d);
    PIX_CE = 1'b0; CPU_WE = 1'b1; CPU_ADDR = a; CPU_DIN = d;
    @(posedge CLK); #1;
    CPU_WE = 1'b0;
    exp_mem[a] = d;
  endtask

  task automatic cpu_rd(input logic [AW-1:0] a, input logic [OW-1:0] exp);
    PIX_CE = 1'b0; CPU_RE = 1'b1; CPU_ADDR = a;
    @(posedge CLK); #1;
    CPU_RE = 1'b0;
    chk("rd_rdy", 32'(CPU_RDY), 32'd1);
    chk("rd_dout", 32'(CPU_DOUT), 32'(exp));
    @(posedge CLK); #1;
    chk("rd_rdy_drop", 32'(CPU_RDY), 32'd0);
  endtask

  task automatic wait_init(output int n);
    n = 0;
    while (n < 1000) begin
      @(posedge CLK); #1;
      n++;
      if (!BUSY) break;
    end
  endtask

  initial begin
    int n;
    RSTn = 1'b0; PIX_CE = 1'b0; PIX_VLD = 1'b0; BANK = 1'b0; OBP = '0; OPQ = '0;
    EN1n = 1'b0; EN2n = 1'b0; CPU_WE = 1'b0; CPU_RE = 1'b0; CPU_ADDR = '0; CPU_DIN = '0;
    INIT_REQ = 1'b0; have_last = 1'b0; tb_busy = 1'b0; last = '0;
    for (int i = 0; i < 256; i++) exp_mem[i] = ref_def(AW'(i));

    repeat (3) @(posedge CLK);
    #1;
    chk("rst_q", 32'(Q), 32'hF);
    chk("rst_qvld", 32'(Q_VLD), 32'd0);
    chk("rst_dout", 32'(CPU_DOUT), 32'd0);
    chk("rst_rdy", 32'(CPU_RDY), 32'd0);
    chk("rst_busy", 32'(BUSY), 32'd1);

    PIX_CE = 1'b1;
    @(negedge CLK);
    RSTn = 1'b1;
    wait_init(n);
    chk("init_cycles", 32'(n), 32'd256);

    pix(1'b1, 1'b1, 1'b0, 3'd5, 4'b0110, 1'b0, 1'b0);
    pix(1'b1, 1'b1, 1'b0, 3'd5, 4'b1000, 1'b0, 1'b0);
    pix(1'b1, 1'b1, 1'b0, 3'd5, 4'b0000, 1'b0, 1'b0);
    for (int i = 0; i < 24; i++)
      pix(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), PB'($urandom_range(0, 7)),
          NL'($urandom_range(0, 15)), ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
    drain();

    cpu_wr(8'h86, 4'h2);
    pix(1'b1, 1'b1, 1'b1, 3'd0, 4'b0110, 1'b0, 1'b0);
    pix(1'b1, 1'b1, 1'b0, 3'd0, 4'b0110, 1'b0, 1'b0);
    drain();
    cpu_rd(8'h86, 4'h2);

    PIX_CE = 1'b0; CPU_WE = 1'b1; CPU_RE = 1'b1; CPU_ADDR = 8'h10; CPU_DIN = 4'h7;
    @(posedge CLK); #1;
    CPU_WE = 1'b0; CPU_RE = 1'b0;
    exp_mem[8'h10] = 4'h7;
    chk("wr_rd_old", 32'(CPU_DOUT), 32'hF);
    cpu_rd(8'h10, 4'h7);

    pix(1'b1, 1'b1, 1'b0, 3'd1, 4'b0100, 1'b0, 1'b0);
    pix(1'b1, 1'b1, 1'b0, 3'd1, 4'b0101, 1'b1, 1'b0);
    pix(1'b1, 1'b1, 1'b1, 3'd0, 4'b0110, 1'b0, 1'b0);
    pix(1'b1, 1'b0, 1'b1, 3'd0, 4'b0110, 1'b0, 1'b1);
    pix(1'b1, 1'b1, 1'b0, 3'd2, 4'b1010, 1'b0, 1'b0);

    pix(1'b1, 1'b1, 1'b0, 3'd3, 4'b1100, 1'b0, 1'b0);
    pix(1'b0, 1'b0, 1'b1, 3'd7, 4'b0001, 1'b1, 1'b1);
    pix(1'b0, 1'b1, 1'b0, 3'd6, 4'b0000, 1'b0, 1'b0);
    pix(1'b1, 1'b0, 1'b1, 3'd0, 4'b0110, 1'b0, 1'b0);
    pix(1'b1, 1'b1, 1'b0, 3'd4, 4'b1000, 1'b0, 1'b0);
    drain();

    cpu_wr(8'h86, 4'hA);
    drain();
    PIX_CE = 1'b0; INIT_REQ = 1'b1;
    @(posedge CLK); #1;
    INIT_REQ = 1'b0;
    chk("ireq_busy", 32'(BUSY), 32'd1);
    n = 1;
    tb_busy = 1'b1;
    for (int i = 0; i < 256; i++) begin
      if (i == 50) begin
        CPU_WE = 1'b1; CPU_RE = 1'b1; CPU_ADDR = 8'h86; CPU_DIN = 4'h5; INIT_REQ = 1'b1;
      end
      if (i < 255)
        pix(1'b1, 1'($urandom_range(0, 1)), 1'b1, 3'd0, NL'($urandom_range(0, 15)), 1'b0, 1'b0);
      else
        drain();
      CPU_WE = 1'b0; CPU_RE = 1'b0; INIT_REQ = 1'b0;
      if (i == 50) chk("init_no_rdy", 32'(CPU_RDY), 32'd0);
      if (BUSY) n++;
    end
    tb_busy = 1'b0;
    chk("reinit_cycles", 32'(n), 32'd256);
    chk("reinit_done", 32'(BUSY), 32'd0);
    for (int i = 0; i < 256; i++) exp_mem[i] = ref_def(AW'(i));
    cpu_rd(8'h86, 4'h1);
    pix(1'b1, 1'b1, 1'b1, 3'd0, 4'b0110, 1'b0, 1'b0);
    pix(1'b1, 1'b1, 1'b0, 3'd5, 4'b1000, 1'b0, 1'b0);
    drain();

    PIX_CE = 1'b0; INIT_REQ = 1'b1;
    @(posedge CLK); #1;
    INIT_REQ = 1'b0;
    tb_busy = 1'b1;
    for (int i = 0; i < 100; i++) pix(1'b1, 1'b1, 1'b0, 3'd2, 4'b0010, 1'b0, 1'b0);
    RSTn = 1'b0;
    #2;
    chk("abort_q", 32'(Q), 32'hF);
    chk("abort_qvld", 32'(Q_VLD), 32'd0);
    chk("abort_dout", 32'(CPU_DOUT), 32'd0);
    chk("abort_rdy", 32'(CPU_RDY), 32'd0);
    chk("abort_busy", 32'(BUSY), 32'd1);
    sb.delete();
    have_last = 1'b0;
    tb_busy = 1'b0;
    PIX_CE = 1'b0;
    @(negedge CLK);
    RSTn = 1'b1;
    wait_init(n);
    chk("abort_init_cycles", 32'(n), 32'd256);
    pix(1'b1, 1'b1, 1'b1, 3'd7, 4'b0100, 1'b0, 1'b0);
    pix(1'b1, 1'b1, 1'b0, 3'd0, 4'b0000, 1'b0, 1'b0);
    drain();
    cpu_rd(8'h86, 4'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
